// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus switch.
//   bus_state_t  : switch FSM states (IDLE, WAIT, ERR).
//   slave_index(): extracts the decode field (top decode_bits of an
//                  addr_bits-wide address) as a slave index.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } bus_state_t;

    // Address is passed zero-extended to 64 bits so one function serves
    // every address width; the caller narrows the result.
    function automatic logic [31:0] slave_index(input logic [63:0] addr,
                                                input int addr_bits,
                                                input int decode_bits);
        logic [63:0] shifted;
        shifted = addr >> (addr_bits - decode_bits);
        return shifted[31:0] & ((32'd1 << decode_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/bus_switch_if.sv
// Signal bundle for the single-master / N-slave strobe-ack-retry bus.
//   master modport : the surrounding system (CPU data port driving requests,
//                    slave devices driving read data / ack / retry).
//   slave  modport : the switch itself.
// Master side : m_addr, m_out, m_select, m_write, m_strobe -> switch;
//               m_in, m_ack, m_retry, m_error <- switch.
// Slave side  : s_addr, s_in, s_select, s_write, s_strobe <- switch;
//               s_out, s_ack, s_retry -> switch.
// Fault       : fault_clear -> switch; fault_valid, fault_addr <- switch.
interface bus_switch_if #(
    parameter int ADDR_BITS   = 28,
    parameter int WORD_BITS   = 32,
    parameter int SEL_BITS    = 4,
    parameter int DECODE_BITS = 2
);
    localparam int NUM_SLAVES = 2 ** DECODE_BITS;

    logic [ADDR_BITS-1:0]              m_addr;
    logic [WORD_BITS-1:0]              m_out;
    logic [SEL_BITS-1:0]               m_select;
    logic                              m_write;
    logic                              m_strobe;
    logic [WORD_BITS-1:0]              m_in;
    logic                              m_ack;
    logic                              m_retry;
    logic                              m_error;

    logic [ADDR_BITS-DECODE_BITS-1:0]  s_addr;
    logic [WORD_BITS-1:0]              s_in;
    logic [SEL_BITS-1:0]               s_select;
    logic                              s_write;
    logic [NUM_SLAVES-1:0]             s_strobe;
    logic [NUM_SLAVES*WORD_BITS-1:0]   s_out;
    logic [NUM_SLAVES-1:0]             s_ack;
    logic [NUM_SLAVES-1:0]             s_retry;

    logic                              fault_clear;
    logic                              fault_valid;
    logic [ADDR_BITS-1:0]              fault_addr;

    modport master (
        output m_addr, m_out, m_select, m_write, m_strobe,
        input  m_in, m_ack, m_retry, m_error,
        input  s_addr, s_in, s_select, s_write, s_strobe,
        output s_out, s_ack, s_retry,
        output fault_clear,
        input  fault_valid, fault_addr
    );

    modport slave (
        input  m_addr, m_out, m_select, m_write, m_strobe,
        output m_in, m_ack, m_retry, m_error,
        output s_addr, s_in, s_select, s_write, s_strobe,
        input  s_out, s_ack, s_retry,
        input  fault_clear,
        output fault_valid, fault_addr
    );

endinterface

// File: rtl/bus_watchdog.sv
// Per-transaction ack watchdog.
//   clock, reset : bus clock, synchronous active-high reset.
//   load         : restart the count at 0 (transaction accepted).
//   enable       : a waiting cycle with no ack; advances the count.
//   expire       : this waiting cycle is the TIMEOUT-th since acceptance.
// TIMEOUT = 0 disables the watchdog (expire never asserts).
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count;

    // Saturating counter: it must never wrap back into the expire window.
    always_ff @(posedge clock) begin
        if (reset || load)
            count <= '0;
        else if (enable && (count != '1))
            count <= count + 1'b1;
    end

    assign expire = (TIMEOUT != 0) && enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_switch.sv
// Single-master, N-slave data-bus interconnect with address decode,
// unmapped-region errors, ack timeout and sticky fault-address capture.
//   clock : bus clock.
//   reset : synchronous active-high reset; also forces all combinational
//           outputs low while high.
//   bus   : slave modport of bus_switch_if (master request/response,
//           shared slave request fields, per-slave strobe/ack/retry/data,
//           fault_clear / fault_valid / fault_addr).
module bus_switch
    import bus_pkg::*;
#(
    parameter int ADDR_BITS   = 28,
    parameter int WORD_BITS   = 32,
    parameter int SEL_BITS    = 4,
    parameter int DECODE_BITS = 2,
    parameter logic [2**DECODE_BITS-1:0] PRESENT = 'b1101,
    parameter int TIMEOUT     = 255
) (
    input  logic     clock,
    input  logic     reset,
    bus_switch_if.slave bus
);
    localparam int NUM_SLAVES = 2 ** DECODE_BITS;
    localparam int LOW_BITS   = ADDR_BITS - DECODE_BITS;

    bus_state_t             state, next_state;
    logic [DECODE_BITS-1:0] tgt, owner;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [ADDR_BITS-1:0]   err_addr;
    logic                   mapped, own_ack, expire, wd_enable;
    logic                   accept, err_evt;

    logic [NUM_SLAVES-1:0]  s_strobe_c;
    logic [WORD_BITS-1:0]   m_in_c;
    logic                   m_ack_c, m_retry_c, m_error_c;

    assign tgt       = DECODE_BITS'(slave_index(64'(bus.m_addr), ADDR_BITS, DECODE_BITS));
    assign mapped    = PRESENT[tgt];
    assign own_ack   = bus.s_ack[owner];
    assign wd_enable = (state == WAIT) && !own_ack && !reset;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .load   (accept),
        .enable (wd_enable),
        .expire (expire)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        err_evt    = 1'b0;
        s_strobe_c = '0;
        m_in_c     = '0;
        m_ack_c    = 1'b0;
        m_retry_c  = 1'b0;
        m_error_c  = 1'b0;
        // Unmapped errors are reported against the live address; timeouts
        // against the address latched at acceptance.
        err_addr   = (state == IDLE) ? bus.m_addr : req_addr;

        case (state)
            IDLE: begin
                if (bus.m_strobe) begin
                    if (mapped) begin
                        s_strobe_c[tgt] = 1'b1;
                        if (bus.s_retry[tgt]) begin
                            m_retry_c = 1'b1;
                        end else begin
                            accept     = 1'b1;
                            next_state = WAIT;
                        end
                    end else begin
                        err_evt    = 1'b1;
                        next_state = ERR;
                    end
                end
            end
            WAIT: begin
                // Only one transaction in flight: any new request bounces.
                m_retry_c = bus.m_strobe;
                if (own_ack) begin
                    m_ack_c    = 1'b1;
                    m_in_c     = bus.s_out[owner*WORD_BITS +: WORD_BITS];
                    next_state = IDLE;
                end else if (expire) begin
                    m_ack_c    = 1'b1;
                    m_error_c  = 1'b1;
                    err_evt    = 1'b1;
                    next_state = IDLE;
                end
            end
            ERR: begin
                m_retry_c  = bus.m_strobe;
                m_ack_c    = 1'b1;
                m_error_c  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (reset) begin
            accept     = 1'b0;
            err_evt    = 1'b0;
            s_strobe_c = '0;
            m_in_c     = '0;
            m_ack_c    = 1'b0;
            m_retry_c  = 1'b0;
            m_error_c  = 1'b0;
        end
    end

    assign bus.s_strobe = s_strobe_c;
    assign bus.m_in     = m_in_c;
    assign bus.m_ack    = m_ack_c;
    assign bus.m_retry  = m_retry_c;
    assign bus.m_error  = m_error_c;

    // Shared slave request fields are plain pass-through, held low in reset.
    assign bus.s_addr   = reset ? '0   : bus.m_addr[LOW_BITS-1:0];
    assign bus.s_in     = reset ? '0   : bus.m_out;
    assign bus.s_select = reset ? '0   : bus.m_select;
    assign bus.s_write  = reset ? 1'b0 : bus.m_write;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            req_addr <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                owner    <= tgt;
                req_addr <= bus.m_addr;
            end
        end
    end

    // Sticky fault: a new error wins over a simultaneous clear, and the
    // address is only taken on the 0->1 edge so it records the first error.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.fault_valid <= 1'b0;
            bus.fault_addr  <= '0;
        end else if (err_evt) begin
            bus.fault_valid <= 1'b1;
            if (!bus.fault_valid)
                bus.fault_addr <= err_addr;
        end else if (bus.fault_clear) begin
            bus.fault_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_switch.sv
// Self-checking bench for bus_switch: directed stimulus with a response
// scoreboard (expected m_in / m_error pushed at request time, popped on
// every m_ack) plus direct checks of strobes, retries and the fault register.
module tb_bus_switch;

    logic clock = 1'b0;
    logic reset = 1'b1;

    bus_switch_if bus ();

    bus_switch #(.TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Scoreboard consumer: every completed transaction must match the head.
    always @(negedge clock) begin
        if (bus.m_ack === 1'b1) begin
            exp_t e;
            n_acks++;
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("rdata", 64'(bus.m_in), 64'(e.data));
                check("error", 64'(bus.m_error), 64'(e.err));
            end
        end
    end

    initial begin
        int nretry;
        int lat;
        bit got;

        bus.m_addr = '0;  bus.m_out = '0; bus.m_select = '0; bus.m_write = 1'b0;
        bus.m_strobe = 1'b0; bus.fault_clear = 1'b0;
        bus.s_out = '0; bus.s_ack = '0; bus.s_retry = '0;

        // Reset: outputs forced low even with a live request present.
        reset = 1'b1;
        bus.m_strobe = 1'b1;
        bus.m_addr   = 28'h000_0010;
        smp();
        check("rst_strobe", 64'(bus.s_strobe), 64'd0);
        check("rst_ack",    64'(bus.m_ack),    64'd0);
        check("rst_retry",  64'(bus.m_retry),  64'd0);
        check("rst_min",    64'(bus.m_in),     64'd0);
        check("rst_fv",     64'(bus.fault_valid), 64'd0);
        check("rst_fa",     64'(bus.fault_addr),  64'd0);
        cyc();
        reset = 1'b0;
        bus.m_strobe = 1'b0;
        cyc();

        // Read slave 0, 1-cycle slave latency.
        bus.m_addr = 28'h000_0010;
        bus.m_strobe = 1'b1;
        smp();
        check("t1_strobe", 64'(bus.s_strobe), 64'b0001);
        check("t1_saddr",  64'(bus.s_addr),   64'h10);
        push(32'h1234_5678, 1'b0);
        cyc();
        bus.m_strobe = 1'b0;
        bus.s_ack = 4'b0001;
        bus.s_out[0 +: 32] = 32'h1234_5678;
        smp();
        check("t1_strobe_gone", 64'(bus.s_strobe), 64'd0);
        check("t1_ack",         64'(bus.m_ack),    64'd1);
        cyc();
        bus.s_ack = '0;
        smp();
        check("t1_ack_once", 64'(bus.m_ack), 64'd0);
        cyc();

        // Unmapped index 1: error response next cycle, fault captured.
        bus.m_addr = 28'h400_0000;
        bus.m_strobe = 1'b1;
        smp();
        check("t2_nostrobe", 64'(bus.s_strobe), 64'd0);
        check("t2_noretry",  64'(bus.m_retry),  64'd0);
        push(32'h0, 1'b1);
        cyc();
        bus.m_strobe = 1'b0;
        smp();
        check("t2_ack", 64'(bus.m_ack), 64'd1);
        check("t2_fv",  64'(bus.fault_valid), 64'd1);
        check("t2_fa",  64'(bus.fault_addr),  64'h400_0000);
        cyc();

        // Slave 2 retries three cycles, then accepts a write.
        bus.m_addr   = 28'h800_0040;
        bus.m_write  = 1'b1;
        bus.m_out    = 32'hDEAD_BEEF;
        bus.m_select = 4'b0011;
        bus.s_retry  = 4'b0100;
        bus.m_strobe = 1'b1;
        nretry = 0;
        repeat (3) begin
            smp();
            if (bus.m_retry === 1'b1) nretry++;
            check("t3_retry_strobe", 64'(bus.s_strobe), 64'b0100);
            check("t3_retry_noack",  64'(bus.m_ack),    64'd0);
            cyc();
        end
        check("t3_retry_cycles", 64'(nretry), 64'd3);
        bus.s_retry = '0;
        smp();
        check("t3_accept_noretry", 64'(bus.m_retry),  64'd0);
        check("t3_swrite",         64'(bus.s_write),  64'd1);
        check("t3_sin",            64'(bus.s_in),     64'hDEAD_BEEF);
        check("t3_ssel",           64'(bus.s_select), 64'b0011);
        check("t3_saddr",          64'(bus.s_addr),   64'h40);
        push(32'hCAFE_0002, 1'b0);
        cyc();
        bus.m_strobe = 1'b0;
        bus.m_write  = 1'b0;
        bus.s_ack    = 4'b0001;          // non-owner ack must be ignored
        bus.s_out[0 +: 32] = 32'hBAD0_0000;
        smp();
        check("t3_foreign_ack", 64'(bus.m_ack), 64'd0);
        cyc();
        bus.s_ack = 4'b0100;
        bus.s_out[64 +: 32] = 32'hCAFE_0002;
        smp();
        check("t3_ack", 64'(bus.m_ack), 64'd1);
        cyc();
        bus.s_ack = '0;

        // Slave 3 never acks: timeout after 8 cycles; retry during WAIT.
        bus.m_addr = 28'hC00_0100;
        bus.m_strobe = 1'b1;
        smp();
        check("t4_strobe", 64'(bus.s_strobe), 64'b1000);
        push(32'h0, 1'b1);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            lat++;
            bus.m_strobe = (lat == 3);
            bus.m_addr   = (lat == 3) ? 28'h000_0020 : 28'hC00_0100;
            smp();
            if (lat == 3) begin
                check("t5_wait_retry",    64'(bus.m_retry),  64'd1);
                check("t5_wait_nostrobe", 64'(bus.s_strobe), 64'd0);
            end
            if (bus.m_ack === 1'b1) got = 1'b1;
        end
        check("t4_timeout_seen", 64'(got), 64'd1);
        check("t4_latency",      64'(lat), 64'd8);
        check("t4_fa_kept",      64'(bus.fault_addr),  64'h400_0000);
        check("t4_fv",           64'(bus.fault_valid), 64'd1);
        cyc();
        bus.m_strobe = 1'b0;
        bus.fault_clear = 1'b1;
        cyc();
        bus.fault_clear = 1'b0;
        smp();
        check("t4_cleared", 64'(bus.fault_valid), 64'd0);
        cyc();

        // Error and clear in the same cycle: set wins, new address captured.
        bus.m_addr = 28'h400_0080;
        bus.m_strobe = 1'b1;
        bus.fault_clear = 1'b1;
        push(32'h0, 1'b1);
        cyc();
        bus.m_strobe = 1'b0;
        bus.fault_clear = 1'b0;
        smp();
        check("setwin_fv", 64'(bus.fault_valid), 64'd1);
        check("setwin_fa", 64'(bus.fault_addr),  64'h400_0080);
        cyc();

        // Reset mid-WAIT: no ack, late slave ack dropped.
        bus.m_addr = 28'h000_0030;
        bus.m_strobe = 1'b1;
        smp();
        check("t6_strobe", 64'(bus.s_strobe), 64'b0001);
        cyc();
        reset = 1'b1;
        smp();
        check("t6_rst_ack",    64'(bus.m_ack),    64'd0);
        check("t6_rst_retry",  64'(bus.m_retry),  64'd0);
        check("t6_rst_strobe", 64'(bus.s_strobe), 64'd0);
        cyc();
        reset = 1'b0;
        bus.m_strobe = 1'b0;
        bus.s_ack = 4'b0001;
        bus.s_out[0 +: 32] = 32'h5555_AAAA;
        smp();
        check("t6_late_ack", 64'(bus.m_ack), 64'd0);
        check("t6_fv_reset", 64'(bus.fault_valid), 64'd0);
        cyc();
        bus.s_ack = '0;
        cyc();

        check("sb_drained", 64'(sb.size()), 64'd0);
        check("ack_count",  64'(n_acks),    64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_switch.md
Name: bus_switch

Overview:
- Parametrised single-master, N-slave data-bus interconnect on the strobe/ack/retry bus used by the CPU data port.
- Replaces the hand-wired per-device address decode and response muxing in the SoC top level.
- Adds features the hand-wired decode lacks: a population mask for unmapped regions, error responses, a per-transaction timeout watchdog, and a sticky fault-address capture.
- Sits between the RISCV data port and the RAM, UART and Video slaves.

Parameters:
- ADDR_BITS, 28, master address width.
- WORD_BITS, 32, data width.
- SEL_BITS, 4, byte-select width.
- DECODE_BITS, 2, number of top address bits used for decode. NUM_SLAVES = 2**DECODE_BITS (localparam).
- PRESENT, 'b1101, per-index populated mask. Bit i set means slave i exists.
- TIMEOUT, 255, cycles to wait for ack before returning an error. 0 disables the watchdog.

Ports:
- clock  in  1  bus clock.
- reset  in  1  synchronous, active-high reset.
- m_addr  in  ADDR_BITS  master address.
- m_out  in  WORD_BITS  master write data.
- m_select  in  SEL_BITS  byte selects.
- m_write  in  1  write enable.
- m_strobe  in  1  request valid.
- m_in  out  WORD_BITS  read data to master.
- m_ack  out  1  transaction complete.
- m_retry  out  1  request not accepted; master re-presents it next cycle.
- m_error  out  1  qualifies m_ack as a failed transaction.
- s_addr  out  ADDR_BITS-DECODE_BITS  low address bits, shared by all slaves.
- s_in  out  WORD_BITS  write data, shared = m_out.
- s_select  out  SEL_BITS  shared = m_select.
- s_write  out  1  shared = m_write.
- s_strobe  out  NUM_SLAVES  one-hot per-slave strobe.
- s_out  in  NUM_SLAVES*WORD_BITS  slave read data; slave i occupies [i*WORD_BITS +: WORD_BITS].
- s_ack  in  NUM_SLAVES  per-slave ack.
- s_retry  in  NUM_SLAVES  per-slave retry.
- fault_clear  in  1  clears fault_valid.
- fault_valid  out  1  sticky: an error has occurred.
- fault_addr  out  ADDR_BITS  address of the first error since the last clear.

Behaviour:
- Target index t = m_addr[ADDR_BITS-1 -: DECODE_BITS]. The request is mapped iff PRESENT[t].
- States: IDLE, WAIT, ERR. There is at most one outstanding transaction.
- IDLE, mapped request:
  - s_strobe[t] = m_strobe, combinational, same cycle.
  - If s_retry[t] is set that cycle: m_retry = 1 and the state stays IDLE.
  - Otherwise the request is accepted: go to WAIT, owner <= t, count <= 0.
- IDLE, unmapped request with m_strobe:
  - No s_strobe is raised. The request is accepted and the state goes to ERR.
  - fault_addr is latched if fault_valid is 0.
- WAIT:
  - m_ack = s_ack[owner]. m_in = s_out[owner] when acked, else 0.
  - On ack: go to IDLE.
  - Acks from non-owner slaves are ignored.
  - count increments each cycle without ack.
  - If TIMEOUT != 0 and count == TIMEOUT-1 with no ack: in that cycle m_ack = 1, m_error = 1, m_in = 0; capture fault; go to IDLE. Latency to error is TIMEOUT cycles after acceptance.
- ERR: lasts exactly one cycle. m_ack = 1, m_error = 1, m_in = 0; then go to IDLE.
- m_strobe in WAIT or ERR, including the ack cycle: m_retry = 1, no s_strobe. The master must re-present the request; there is no back-to-back issue on an ack cycle.
- Read latency equals slave latency. A slave acking in the cycle after acceptance gives 1-cycle latency.
- s_retry is only considered in the strobe cycle. s_ack and s_retry are never both expected from the owner; if they are, ack wins.
- Late ack after a timeout, while IDLE: dropped. If the same slave is the new owner, a stale ack is indistinguishable from a real one. This is a documented limitation and is not verified.
- Fault register:
  - fault_valid sets on any error. It holds until fault_clear or reset.
  - fault_addr captures only on the 0->1 transition of fault_valid.
  - An error and fault_clear in the same cycle: set wins.
- count is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
- Reset values:
  - State IDLE.
  - s_strobe, m_ack, m_retry, m_error all 0; m_in 0.
  - fault_valid 0, fault_addr 0.
  - Combinational outputs are forced to 0 while reset is high.
- Reset mid-transaction aborts the transaction silently. No ack is issued, and a later slave ack is dropped.

Decomposition:
- Shared package bus_pkg holds:
  - typedef enum bus_state_t {IDLE, WAIT, ERR}.
  - A function slave_index(addr) for the decode.
- One sub-module: bus_watchdog (load/enable/expire counter, parametrised by TIMEOUT).

Test Plan:
- Read slave 0 at m_addr 'h000_0010, slave acks 1 cycle later with 'h1234_5678 -> m_ack for 1 cycle, m_in = 'h1234_5678, m_error 0, s_strobe = 'b0001 only in the strobe cycle.
- Access m_addr 'h400_0000 (index 1, not PRESENT) -> no s_strobe; next cycle m_ack = 1, m_error = 1; fault_valid = 1, fault_addr = 'h400_0000.
- Slave 2 returns s_retry for 3 cycles, then accepts -> m_retry high 3 cycles; the ack arrives only after acceptance.
- TIMEOUT = 8, slave 3 never acks -> m_ack = m_error = 1 exactly 8 cycles after acceptance; a second error leaves fault_addr unchanged; fault_clear then drops fault_valid.
- New strobe during WAIT -> m_retry = 1 and no s_strobe. Reset asserted mid-WAIT -> all outputs 0 next cycle and the late slave ack is not forwarded.
